fp_stream_accum: RTL

FP_STREAM_ACCUM -- requirements
Module: fp_stream_accum

---
 rtl/fp_stream_accum.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fp_stream_accum.sv
// ---------------------------------------------------------------------------
// fp_stream_accum
//   Streaming IEEE-754 single-precision reduction. After a start pulse the
//   block accepts `len` elements on a valid/ready stream. It folds each
//   element into an accumulator through an external combinational adder
//   (add_a/add_b -> add_s). It then presents the final sum on a
//   valid/ready output.
//
//   Optional feature macro: FP_ACC_SPECIAL_EN
//     When defined, any accepted element with exponent 0xFF sets a sticky
//     flag. When that flag is set, the result is forced to the quiet NaN
//     0x7FC00000 and out_special is raised. When undefined, out_special is
//     tied low and specials pass straight through to the adder.
//
//   Ports
//     clk          clock, all state on rising edge
//     rst_n        asynchronous active-low reset
//     start        begin a reduction (sampled only while idle)
//     len          element count, latched with start
//     in_valid     in_data carries an operand
//     in_data      operand (IEEE-754 single)
//     in_ready     block accepts in_data this cycle
//     add_a/add_b  operands to the external fp adder (acc, in_data)
//     add_s        sum from the external adder, same cycle
//     out_valid    out_data holds the final sum
//     out_data     final sum (equals acc except for a forced NaN)
//     out_ready    consumer accepts out_data
//     busy         high whenever the FSM is not idle
//     out_special  result is a forced NaN
// ---------------------------------------------------------------------------
module fp_stream_accum #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_s,
  output logic             out_valid,
  output logic [31:0]      out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             out_special
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] REM_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] REM_ZERO = {CNT_W{1'b0}};
  localparam logic [31:0]      ACC_ZERO = 32'h0000_0000;

  state_t           r_state;
  logic [31:0]      r_acc;
  logic [CNT_W-1:0] r_rem;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic             w_accept;

  // An element is consumed only while the block advertises ready.
  assign w_accept  = r_in_ready & in_valid;

  assign add_a     = r_acc;
  assign add_b     = in_data;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

  // Reduction FSM: state, accumulator, remaining count and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_acc       <= ACC_ZERO;
      r_rem       <= REM_ZERO;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_acc  <= ACC_ZERO;
            r_busy <= 1'b1;
            if (len != REM_ZERO) begin
              r_rem      <= len;
              r_in_ready <= 1'b1;
              r_state    <= ST_ACC;
            end else begin
              // Empty reduction: the result is the zero accumulator.
              r_rem       <= REM_ZERO;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACC: begin
          if (w_accept) begin
            r_acc <= add_s;
            r_rem <= r_rem - REM_ONE;
            // Leave on the last element so rem never wraps below zero.
            if (r_rem == REM_ONE) begin
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_state <= ST_ACC;
            end
          end else begin
            r_state <= ST_ACC;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_acc       <= ACC_ZERO;
          r_rem       <= REM_ZERO;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef FP_ACC_SPECIAL_EN
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Inf and NaN both carry an all-ones exponent.
  function automatic logic is_special(input logic [31:0] f);
    return (f[30:23] == 8'hFF);
  endfunction

  logic r_flag;

  // Sticky special-operand flag, cleared by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag <= 1'b0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_flag <= 1'b0;
    end else if (w_accept) begin
      r_flag <= r_flag | is_special(in_data);
    end else begin
      r_flag <= r_flag;
    end
  end

  // The NaN override shows only while a result is being presented.
  assign out_special = r_out_valid & r_flag;
  assign out_data    = (r_out_valid & r_flag) ? QNAN : r_acc;
`else
  assign out_special = 1'b0;
  assign out_data    = r_acc;
`endif

endmodule
